// File: rtl/pipe_hazard_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctl_pkg
// Description : Shared constants for the pipeline hazard/flush controller:
//               scoreboard depth, FSM state encodings, stall counter width
//               and the saturating-increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctl_pkg;

    // Scoreboard slots: S0 = EX, S1 = MEM, S2 = WB
    localparam int NUM_SLOTS   = 3;

    // Stall counter width
    localparam int STALL_CNT_W = 16;

    // FSM state encodings (exported on ow_state)
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == {STALL_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage : pipe_hazard_ctl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctl_slot_pipe.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctl_slot_pipe
// Description : Three-slot in-flight write scoreboard (EX, MEM, WB). Shifts
//               every cycle; S0 captures the ID instruction when i_load is
//               high, otherwise becomes a bubble.
// Ports       : i_clk/i_rst_n      clock, async active-low reset
//               i_load             capture ID fields into S0
//               i_gp_we/i_gp       ID target GP write enable / index
//               i_is_load/i_sr_we  ID is a load / writes an SR
//               i_src_gp/i_tgt_gp  indices to look up against the slots
//               o_src_match        per-slot GP match for i_src_gp
//               o_tgt_match        per-slot GP match for i_tgt_gp
//               o_s0_load          S0 holds a valid load
//               o_sr_pend          some valid slot writes an SR
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctl_slot_pipe
    import pipe_hazard_ctl_pkg::*;
#(
    parameter int GP_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load,
    input  logic                 i_gp_we,
    input  logic [GP_W-1:0]      i_gp,
    input  logic                 i_is_load,
    input  logic                 i_sr_we,
    input  logic [GP_W-1:0]      i_src_gp,
    input  logic [GP_W-1:0]      i_tgt_gp,
    output logic [NUM_SLOTS-1:0] o_src_match,
    output logic [NUM_SLOTS-1:0] o_tgt_match,
    output logic                 o_s0_load,
    output logic                 o_sr_pend
);

    logic [NUM_SLOTS-1:0] r_v;
    logic [NUM_SLOTS-1:0] r_gp_we;
    logic [NUM_SLOTS-1:0] r_is_load;
    logic [NUM_SLOTS-1:0] r_sr_we;
    logic [GP_W-1:0]      r_gp [NUM_SLOTS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v       <= '0;
            r_gp_we   <= '0;
            r_is_load <= '0;
            r_sr_we   <= '0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                r_gp[k] <= '0;
            end
        end else begin
            // Flags are gated by i_load so a bubble never carries a stale write
            r_v       <= {r_v[NUM_SLOTS-2:0],       i_load};
            r_gp_we   <= {r_gp_we[NUM_SLOTS-2:0],   i_load & i_gp_we};
            r_is_load <= {r_is_load[NUM_SLOTS-2:0], i_load & i_is_load};
            r_sr_we   <= {r_sr_we[NUM_SLOTS-2:0],   i_load & i_sr_we};
            r_gp[0]   <= i_gp;
            for (int k = 1; k < NUM_SLOTS; k++) begin
                r_gp[k] <= r_gp[k-1];
            end
        end
    end

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_match
        assign o_src_match[k] = r_v[k] & r_gp_we[k] & (r_gp[k] == i_src_gp);
        assign o_tgt_match[k] = r_v[k] & r_gp_we[k] & (r_gp[k] == i_tgt_gp);
    end

    assign o_s0_load = r_v[0] & r_is_load[0];
    assign o_sr_pend = |(r_v & r_sr_we);

endmodule : pipe_hazard_ctl_slot_pipe
`default_nettype wire

// File: rtl/pipe_hazard_ctl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctl
// Description : Hazard and flush controller for the five-stage core. Stalls
//               IF/ID on load-use (or any pending GP write without
//               forwarding) and on SR read-after-write, and holds the IF/ID
//               flush for FLUSH_CYC cycles after a taken branch.
// Ports       : iw_clk/iw_rst_n    clock, async active-low reset
//               iw_id_*            ID decode fields
//               iw_ex_branch_taken EX resolved a taken branch this cycle
//               ow_stall           hold PC/IF/ID, bubble into EX
//               ow_flush           flush IF/ID latches
//               ow_state           FSM state (0 RUN, 1 FLUSH)
//               ow_stall_cnt       saturating stall-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctl
    import pipe_hazard_ctl_pkg::*;
#(
    parameter int GP_W      = 4,
    parameter int SR_W      = 2,
    parameter int FLUSH_CYC = 2,
    parameter int FWD_EN    = 1
) (
    input  logic                   iw_clk,
    input  logic                   iw_rst_n,
    input  logic                   iw_id_valid,
    input  logic [GP_W-1:0]        iw_id_src_gp,
    input  logic                   iw_id_src_gp_en,
    input  logic [GP_W-1:0]        iw_id_tgt_gp,
    input  logic                   iw_id_tgt_rd_en,
    input  logic                   iw_id_tgt_gp_we,
    input  logic                   iw_id_is_load,
    input  logic                   iw_id_src_sr_en,
    input  logic                   iw_id_tgt_sr_we,
    input  logic                   iw_ex_branch_taken,
    output logic                   ow_stall,
    output logic                   ow_flush,
    output logic [1:0]             ow_state,
    output logic [STALL_CNT_W-1:0] ow_stall_cnt
);

    // Remaining flush cycles after the branch cycle and the first FLUSH cycle
    localparam int                c_cnt_w      = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC - 1) : 1;
    localparam logic [c_cnt_w-1:0] c_flush_load = (FLUSH_CYC > 1) ? c_cnt_w'(FLUSH_CYC - 2) : '0;

    logic [NUM_SLOTS-1:0]   w_src_m;
    logic [NUM_SLOTS-1:0]   w_tgt_m;
    logic [NUM_SLOTS-1:0]   w_gp_match;
    logic                   w_s0_load;
    logic                   w_sr_pend;
    logic                   w_gp_hazard;
    logic                   w_sr_hazard;
    logic                   w_load;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // ---------------------------------------------------------------- scoreboard
    assign w_load = iw_id_valid & ~ow_stall & ~ow_flush;

    pipe_hazard_ctl_slot_pipe #(
        .GP_W (GP_W)
    ) u_slots (
        .i_clk       (iw_clk),
        .i_rst_n     (iw_rst_n),
        .i_load      (w_load),
        .i_gp_we     (iw_id_tgt_gp_we),
        .i_gp        (iw_id_tgt_gp),
        .i_is_load   (iw_id_is_load),
        .i_sr_we     (iw_id_tgt_sr_we),
        .i_src_gp    (iw_id_src_gp),
        .i_tgt_gp    (iw_id_tgt_gp),
        .o_src_match (w_src_m),
        .o_tgt_match (w_tgt_m),
        .o_s0_load   (w_s0_load),
        .o_sr_pend   (w_sr_pend)
    );

    // ------------------------------------------------------------ hazard logic
    // src and tgt hits on the same slot OR together into a single hazard
    assign w_gp_match = ({NUM_SLOTS{iw_id_src_gp_en}} & w_src_m)
                      | ({NUM_SLOTS{iw_id_tgt_rd_en}} & w_tgt_m);

    if (FWD_EN != 0) begin : g_fwd
        // Forwarding covers everything except a load still in EX
        assign w_gp_hazard = w_gp_match[0] & w_s0_load;
    end else begin : g_no_fwd
        assign w_gp_hazard = |w_gp_match;
    end

    if (SR_W > 0) begin : g_sr
        // No SR forwarding: wait until the writer drains past WB
        assign w_sr_hazard = iw_id_src_sr_en & w_sr_pend;
    end else begin : g_no_sr
        assign w_sr_hazard = 1'b0;
    end

    assign ow_stall = iw_id_valid & (w_gp_hazard | w_sr_hazard) & ~ow_flush;

    // --------------------------------------------------------------------- FSM
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                // A single-cycle flush is fully covered by the combinational branch cycle
                if (iw_ex_branch_taken && (FLUSH_CYC > 1)) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = c_flush_load;
                end
            end
            ST_FLUSH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        ow_flush = 1'b0;
        case (r_state)
            ST_RUN:   ow_flush = iw_ex_branch_taken;
            ST_FLUSH: ow_flush = 1'b1;
            default:  ow_flush = 1'b0;
        endcase
    end

    assign ow_state = r_state;

    // ---------------------------------------------------------- stall counter
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_stall_cnt <= '0;
        end else if (ow_stall) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign ow_stall_cnt = r_stall_cnt;

endmodule : pipe_hazard_ctl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctl
// Description : Self-checking bench for pipe_hazard_ctl. Two instances share
//               stimulus: u_dut (FWD_EN=1) and u_dut0 (FWD_EN=0). Expected
//               values are queued as each cycle is driven and compared
//               mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  src_gp;
    logic        src_en;
    logic [3:0]  tgt_gp;
    logic        tgt_rd;
    logic        tgt_we;
    logic        is_ld;
    logic        sr_rd;
    logic        sr_we;
    logic        br;

    logic        stall,  stall0;
    logic        flush,  flush0;
    logic [1:0]  state,  state0;
    logic [15:0] cnt,    cnt0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        stall;
        logic        stall0;
        logic        flush;
        logic [1:0]  state;
        logic [15:0] cnt;
        logic [15:0] cnt0;
    } exp_t;

    exp_t exp_q[$];

    pipe_hazard_ctl #(.GP_W(4), .SR_W(2), .FLUSH_CYC(2), .FWD_EN(1)) u_dut (
        .iw_clk             (clk),
        .iw_rst_n           (rst_n),
        .iw_id_valid        (id_valid),
        .iw_id_src_gp       (src_gp),
        .iw_id_src_gp_en    (src_en),
        .iw_id_tgt_gp       (tgt_gp),
        .iw_id_tgt_rd_en    (tgt_rd),
        .iw_id_tgt_gp_we    (tgt_we),
        .iw_id_is_load      (is_ld),
        .iw_id_src_sr_en    (sr_rd),
        .iw_id_tgt_sr_we    (sr_we),
        .iw_ex_branch_taken (br),
        .ow_stall           (stall),
        .ow_flush           (flush),
        .ow_state           (state),
        .ow_stall_cnt       (cnt)
    );

    pipe_hazard_ctl #(.GP_W(4), .SR_W(2), .FLUSH_CYC(2), .FWD_EN(0)) u_dut0 (
        .iw_clk             (clk),
        .iw_rst_n           (rst_n),
        .iw_id_valid        (id_valid),
        .iw_id_src_gp       (src_gp),
        .iw_id_src_gp_en    (src_en),
        .iw_id_tgt_gp       (tgt_gp),
        .iw_id_tgt_rd_en    (tgt_rd),
        .iw_id_tgt_gp_we    (tgt_we),
        .iw_id_is_load      (is_ld),
        .iw_id_src_sr_en    (sr_rd),
        .iw_id_tgt_sr_we    (sr_we),
        .iw_ex_branch_taken (br),
        .ow_stall           (stall0),
        .ow_flush           (flush0),
        .ow_state           (state0),
        .ow_stall_cnt       (cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_idle();
        id_valid = 0; src_gp = 0; src_en = 0; tgt_gp = 0; tgt_rd = 0;
        tgt_we = 0; is_ld = 0; sr_rd = 0; sr_we = 0; br = 0;
    endtask

    // One cycle: drive ID/EX inputs after the edge, queue the expectation,
    // then compare against the DUTs at the falling edge.
    task automatic step(input logic v, input logic s_en, input logic [3:0] s,
                        input logic t_rd, input logic [3:0] t, input logic we,
                        input logic ld, input logic srr, input logic srw, input logic b,
                        input logic e_stall, input logic e_stall0, input logic e_flush,
                        input logic [1:0] e_state, input logic [15:0] e_cnt,
                        input logic [15:0] e_cnt0);
        exp_t e;
        exp_t got;
        @(posedge clk);
        #1;
        id_valid = v; src_en = s_en; src_gp = s; tgt_rd = t_rd; tgt_gp = t;
        tgt_we = we; is_ld = ld; sr_rd = srr; sr_we = srw; br = b;
        e.stall = e_stall; e.stall0 = e_stall0; e.flush = e_flush;
        e.state = e_state; e.cnt = e_cnt; e.cnt0 = e_cnt0;
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        check("stall",  {31'd0, stall},  {31'd0, got.stall});
        check("stall0", {31'd0, stall0}, {31'd0, got.stall0});
        check("flush",  {31'd0, flush},  {31'd0, got.flush});
        check("state",  {30'd0, state},  {30'd0, got.state});
        check("cnt",    {16'd0, cnt},    {16'd0, got.cnt});
        check("cnt0",   {16'd0, cnt0},   {16'd0, got.cnt0});
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_cnt",   {16'd0, cnt},   32'd0);
        rst_n = 1'b1;

        //    v s_en s  t_rd t  we ld srr srw br | stall st0 fl state cnt cnt0
        // Load-use: LD r3, then ADD reading r3
        step(1, 0, 0, 0, 3, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 0, 4, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0);
        step(1, 1, 3, 0, 4, 1, 0, 0, 0, 0,   0, 1, 0, 0, 1, 1);
        check("lu_s0_empty", {29'd0, u_dut.u_slots.r_v}, 32'b010);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 2);
        // ALU producer r3, then consumer of r3 (forwarded vs. not)
        step(1, 0, 0, 0, 3, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 2);
        step(1, 1, 3, 0, 6, 1, 0, 0, 0, 0,   0, 1, 0, 0, 1, 2);
        step(1, 1, 3, 0, 6, 1, 0, 0, 0, 0,   0, 1, 0, 0, 1, 3);
        step(1, 1, 3, 0, 6, 1, 0, 0, 0, 0,   0, 1, 0, 0, 1, 4);
        step(1, 1, 3, 0, 6, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 5);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 5);
        // SR hazard: SRMOV writes SR, then SRJCC reads it
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 5);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 1, 5);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 2, 6);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 3, 7);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 4, 8);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 4, 8);
        check("sr_enter_s0", {31'd0, u_dut.u_slots.r_v[0]}, 32'd1);
        // Taken branch with live ID instructions: S0 must stay empty
        step(1, 0, 0, 0, 7, 1, 0, 0, 0, 1,   0, 0, 1, 0, 4, 8);
        step(1, 0, 0, 0, 7, 1, 0, 0, 0, 0,   0, 0, 1, 1, 4, 8);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 4, 8);
        check("br_s0s1_empty", {30'd0, u_dut.u_slots.r_v[1:0]}, 32'd0);
        // Load-use and branch in the same cycle: flush wins
        step(1, 0, 0, 0, 8, 1, 1, 0, 0, 0,   0, 0, 0, 0, 4, 8);
        step(1, 1, 8, 0, 9, 1, 0, 0, 0, 1,   0, 0, 1, 0, 4, 8);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 4, 8);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 4, 8);
        // Target-as-operand hazard (ST r5 after LD r5), matches tgt path
        step(1, 0, 0, 0, 5, 1, 1, 0, 0, 0,   0, 0, 0, 0, 4, 8);
        step(1, 1, 5, 1, 5, 0, 0, 0, 0, 0,   1, 1, 0, 0, 4, 8);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 5, 9);
        // Reset in the middle of a flush
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 5, 9);
        @(posedge clk);
        #1;
        drive_idle();
        check("mid_flush", {31'd0, flush}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstf_flush", {31'd0, flush}, 32'd0);
        check("rstf_state", {30'd0, state}, 32'd0);
        check("rstf_slots", {29'd0, u_dut.u_slots.r_v}, 32'd0);
        check("rstf_cnt",   {16'd0, cnt},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation: SR read+write instruction stalls 3 of every 4 cycles
        @(posedge clk);
        #1;
        id_valid = 1; sr_rd = 1; sr_we = 1;
        repeat (87400) @(posedge clk);
        @(negedge clk);
        check("sat_cnt",  {16'd0, cnt},  32'h0000_FFFF);
        check("sat_cnt0", {16'd0, cnt0}, 32'h0000_FFFF);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("sat_hold", {16'd0, cnt}, 32'h0000_FFFF);
        drive_idle();

        if (exp_q.size() != 0) begin
            check("queue_empty", exp_q.size(), 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pipe_hazard_ctl
`default_nettype wire

// File: doc/pipe_hazard_ctl.md
# pipe_hazard_ctl

Pipeline hazard and flush controller for the five-stage core. Tracks in-flight register writes issued past ID in a three-slot scoreboard (EX, MEM, WB). Stalls IF/ID on load-use and special-register (SR) hazards, and sequences multi-cycle flushes on taken branches. Sits beside the ID stage: it consumes ID decode fields and the EX branch outcome, and drives the flush/stall lines of IF and ID.

## Interface
Parameters:
- GP_W, 4: general-purpose register index width.
- SR_W, 2: special-register index width.
- FLUSH_CYC, 2: cycles `ow_flush` stays high per taken branch (≥1).
- FWD_EN, 1: 1 = EX/MEM/WB forwarding exists, so only load-use stalls; 0 = stall on any pending GP write.

Ports:
- iw_clk  in  1  clock, rising edge.
- iw_rst_n  in  1  reset, asynchronous, active-low.
- iw_id_valid  in  1  ID latch holds a real instruction, not a bubble.
- iw_id_src_gp  in  GP_W  ID source GP index.
- iw_id_src_gp_en  in  1  source GP is read.
- iw_id_tgt_gp  in  GP_W  ID target GP index.
- iw_id_tgt_rd_en  in  1  target GP is also read as an operand (ALU, CMP, ST).
- iw_id_tgt_gp_we  in  1  instruction writes the target GP.
- iw_id_is_load  in  1  instruction is LDu.
- iw_id_src_sr_en  in  1  instruction reads an SR (SRMOVu, SRJCCu).
- iw_id_tgt_sr_we  in  1  instruction writes an SR.
- iw_ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle.
- ow_stall  out  1  hold PC, IF and ID; insert a bubble into EX.
- ow_flush  out  1  flush IF/ID latches.
- ow_state  out  2  FSM state: 0 RUN, 1 FLUSH.
- ow_stall_cnt  out  16  saturating count of stall cycles.

## Operation
- Scoreboard: slots S0 (EX), S1 (MEM), S2 (WB). Each slot holds {v, gp_we, gp, is_load, sr_we}.
- Every posedge: S2<=S1, S1<=S0. S0 loads the ID fields when `iw_id_valid & !ow_stall & !ow_flush`; otherwise S0 is cleared.
- Match for slot k: `v & gp_we & gp==R`, where R is `iw_id_src_gp` (if src_gp_en) or `iw_id_tgt_gp` (if tgt_rd_en).
- GP hazard when FWD_EN=1: match on S0 with S0.is_load. This is a load-use hazard and costs one stall cycle.
- GP hazard when FWD_EN=0: match on any slot.
- SR hazard: `iw_id_src_sr_en` and any valid slot has sr_we. There is no SR forwarding, so the stall lasts until the write drains past WB.
- `ow_stall = iw_id_valid & (gp_hazard | sr_hazard) & !ow_flush`.
- FSM states:
  - RUN: `iw_ex_branch_taken` makes `ow_flush` high combinationally in that cycle. If FLUSH_CYC>1, go to FLUSH with cnt=FLUSH_CYC-2.
  - FLUSH: `ow_flush`=1. If cnt==0, go to RUN; else cnt-=1.
  - A taken branch while in FLUSH is ignored; flushed instructions cannot be branches.
- Stall counter: increments each cycle `ow_stall`=1 and saturates at 0xFFFF.

## Timing
- Reset (async, while iw_rst_n=0): all slots invalid; state RUN; cnt 0. Outputs: ow_stall=0, ow_flush=0, ow_state=0, ow_stall_cnt=0. Reset mid-flush aborts the flush immediately.
- `ow_stall` is combinational from ID inputs and registered slots, so it is valid in the same cycle.
- The scoreboard updates one cycle later.
- Load-use: the stall is high for exactly one cycle. Next cycle the load is in S1 and the hazard clears.
- SR hazard with a writer in S0: 3 stall cycles (S0 to S1 to S2 to gone).
- Flush and stall in the same cycle: flush wins, ow_stall=0, and S0 is cleared.
- `ow_flush` is high for exactly FLUSH_CYC consecutive cycles starting with the branch-taken cycle.
- R matching both src and tgt counts as one hazard. iw_id_valid=0 never stalls.

## Structure
- Shared package `hazard_pkg.vh`:
  - slot record field widths;
  - FSM state encodings ST_RUN=0 and ST_FLUSH=1;
  - the STALL_CNT_W=16 constant.
- GP/SR widths come from the existing sizes header.
- One natural sub-module: `hazard_slot_pipe`, the three-slot shift register with per-slot GP match outputs.
- Hazard logic, FSM and counter stay in the top module.

## Test plan
- Load-use: ID=LDu writing r3. Next ID=ADDu reading src r3 (FWD_EN=1) -> ow_stall=1 for one cycle; S0 empty next cycle; ow_stall_cnt=1.
- No hazard: ID=ADDu writing r3. Next ID reads r3 (FWD_EN=1) -> ow_stall=0. With FWD_EN=0 -> ow_stall=1 for 3 cycles.
- SR hazard: SRMOVu writes an SR. Next ID=SRJCCu -> ow_stall=1 for 3 cycles, then the instruction enters S0.
- Branch: iw_ex_branch_taken pulsed one cycle, FLUSH_CYC=2 -> ow_flush=1 for 2 cycles, ow_state 0→1→0, and S0 empty both cycles.
- Simultaneous: load-use hazard and branch taken in the same cycle -> ow_flush=1, ow_stall=0, stall count unchanged.
- Reset mid-flush: iw_rst_n low during FLUSH -> ow_flush=0 and ow_state=0 immediately, all slots invalid. Also force 65536+ stalls and check ow_stall_cnt holds at 0xFFFF.
